// File: rtl/sevseg_pkg.sv
// Shared constants for the seven-segment display path: LED polarity, fixed
// segment patterns, the hex glyph table and the scanner's small types.
package sevseg_pkg;

  localparam logic LED_ON  = 1'b0;
  localparam logic LED_OFF = 1'b1;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;

  // Active-low {g,f,e,d,c,b,a}; entry [15] is listed first.
  localparam logic [15:0][6:0] GLYPHS = {
    7'b0001110,  // F
    7'b0000110,  // E
    7'b0100001,  // d
    7'b1000110,  // C
    7'b0000011,  // b
    7'b0001000,  // A
    7'b0010000,  // 9
    7'b0000000,  // 8
    7'b1111000,  // 7
    7'b0000010,  // 6
    7'b0010010,  // 5
    7'b0011001,  // 4
    7'b0110000,  // 3
    7'b0100100,  // 2
    7'b1111001,  // 1
    7'b1000000   // 0
  };

  typedef struct packed {
    logic [3:0] d0;
    logic [3:0] d1;
    logic       sign;
  } disp_val_t;

  localparam disp_val_t VAL_RESET = '{d0: 4'h0, d1: 4'h0, sign: LED_OFF};

  typedef enum logic [1:0] {
    DIG_LO   = 2'd0,
    DIG_HI   = 2'd1,
    DIG_SIGN = 2'd2,
    DIG_PAD  = 2'd3
  } dig_e;

endpackage

// File: rtl/sevseg_decoder.sv
// Combinational hex nibble to active-low seven-segment glyph.
module sevseg_decoder
  import sevseg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = GLYPHS[nibble];

endmodule

// File: rtl/sevseg_scanner.sv
// Four-digit common-anode scanner with frame-aligned double buffering,
// anti-ghost blanking at each slot start and optional leading-zero blanking.
module sevseg_scanner
  import sevseg_pkg::*;
#(
  parameter int unsigned DIV      = 50000,
  parameter int unsigned BLANK    = 500,
  parameter int unsigned LZ_BLANK = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] d0,
  input  logic [3:0] d1,
  input  logic       sign,
  input  logic       load,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       pending
);

  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  dig_e             dig_q, dig_d;
  disp_val_t        staging_q, staging_d;
  disp_val_t        shadow_q, shadow_d;
  logic             pending_q, pending_d;
  logic [3:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;

  disp_val_t  in_s;
  logic       boundary_s;
  logic [3:0] nibble_s;
  logic [6:0] glyph_s;

  assign in_s       = '{d0: d0, d1: d1, sign: sign};
  assign boundary_s = (cnt_q == CNT_LAST) && (dig_q == DIG_PAD);
  assign nibble_s   = (dig_q == DIG_HI) ? shadow_q.d1 : shadow_q.d0;

  sevseg_decoder u_decoder (
    .nibble (nibble_s),
    .seg    (glyph_s)
  );

  // Slot counter and digit index
  always_comb begin
    cnt_d = cnt_q;
    dig_d = dig_q;
    if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
      dig_d = dig_e'(dig_q + 2'd1);
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Staging/shadow buffering; shadow only changes on the frame boundary
  always_comb begin
    staging_d = staging_q;
    shadow_d  = shadow_q;
    pending_d = pending_q;
    if (load) begin
      staging_d = in_s;
      if (boundary_s) begin
        shadow_d  = in_s;
        pending_d = 1'b0;
      end else begin
        pending_d = 1'b1;
      end
    end else if (boundary_s && pending_q) begin
      shadow_d  = staging_q;
      pending_d = 1'b0;
    end else begin
      pending_d = pending_q;
    end
  end

  // Anode/segment selection for the current slot, registered below
  always_comb begin
    an_d  = {4{LED_OFF}};
    seg_d = SEG_BLANK;
    if (cnt_q < BLANK_END) begin
      an_d = {4{LED_OFF}};
    end else begin
      an_d = ~(4'b0001 << dig_q);
      case (dig_q)
        DIG_LO:   seg_d = glyph_s;
        DIG_HI:   seg_d = ((LZ_BLANK != 32'd0) && (shadow_q.d1 == 4'h0)) ? SEG_BLANK : glyph_s;
        DIG_SIGN: seg_d = (shadow_q.sign == LED_ON) ? SEG_MINUS : SEG_BLANK;
        default:  seg_d = SEG_BLANK;
      endcase
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      dig_q     <= DIG_LO;
      staging_q <= VAL_RESET;
      shadow_q  <= VAL_RESET;
      pending_q <= 1'b0;
      an_q      <= {4{LED_OFF}};
      seg_q     <= SEG_BLANK;
    end else begin
      cnt_q     <= cnt_d;
      dig_q     <= dig_d;
      staging_q <= staging_d;
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
      an_q      <= an_d;
      seg_q     <= seg_d;
    end
  end

  assign seg     = seg_q;
  assign an      = an_q;
  assign pending = pending_q;

endmodule

// File: tb/tb_sevseg_scanner.sv
// Scoreboard bench for sevseg_scanner: a cycle-indexed reference model pushes
// expected outputs per clock, a negedge monitor pops and compares them.
module tb_sevseg_scanner;

  localparam int DIV   = 8;
  localparam int BLANK = 2;
  localparam int FRAME = 4 * DIV;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic       load  = 1'b0;
  logic       sign  = 1'b1;
  logic [3:0] d0    = 4'h0;
  logic [3:0] d1    = 4'h0;

  logic [6:0] seg_a, seg_b;
  logic [3:0] an_a, an_b;
  logic       pend_a, pend_b;

  sevseg_scanner #(.DIV(DIV), .BLANK(BLANK), .LZ_BLANK(1)) dut_lz (
    .clk(clk), .rst_n(rst_n), .d0(d0), .d1(d1), .sign(sign), .load(load),
    .seg(seg_a), .an(an_a), .pending(pend_a)
  );

  sevseg_scanner #(.DIV(DIV), .BLANK(BLANK), .LZ_BLANK(0)) dut_nolz (
    .clk(clk), .rst_n(rst_n), .d0(d0), .d1(d1), .sign(sign), .load(load),
    .seg(seg_b), .an(an_b), .pending(pend_b)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] d0;
    logic [3:0] d1;
    logic       s;
  } val_t;

  typedef struct packed {
    int unsigned cyc;
    logic [3:0]  an;
    logic [6:0]  seg_lz;
    logic [6:0]  seg_nolz;
    logic        pend;
  } exp_t;

  logic [6:0] glyph_tb [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  exp_t        sb[$];
  int unsigned edge_cnt = 0;
  int          pass_cnt = 0;
  int          total    = 0;

  int   t;
  val_t shown, staged;
  bit   pend;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    total++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_cnt);
  endtask

  function automatic logic [3:0] exp_an(input int tt);
    logic [3:0] m;
    if ((tt % DIV) < BLANK) return 4'hF;
    m = 4'b0001 << ((tt / DIV) % 4);
    return ~m;
  endfunction

  function automatic logic [6:0] exp_seg(input int tt, input val_t v, input bit lz);
    if ((tt % DIV) < BLANK) return 7'h7F;
    case ((tt / DIV) % 4)
      0:       return glyph_tb[v.d0];
      1:       return (lz && v.d1 == 4'h0) ? 7'h7F : glyph_tb[v.d1];
      2:       return v.s ? 7'h7F : 7'b0111111;
      default: return 7'h7F;
    endcase
  endfunction

  function automatic val_t rnd_val();
    val_t v;
    v.d0 = 4'($urandom_range(0, 15));
    v.d1 = 4'($urandom_range(0, 15));
    v.s  = 1'($urandom_range(0, 1));
    return v;
  endfunction

  // One clock of stimulus; the model predicts the outputs after the next edge
  task automatic step(input bit ld, input val_t v);
    exp_t e;
    bit   bnd;
    @(negedge clk);
    load = ld; d0 = v.d0; d1 = v.d1; sign = v.s;
    bnd        = (t % FRAME) == FRAME - 1;
    e.cyc      = edge_cnt + 1;
    e.an       = exp_an(t);
    e.seg_lz   = exp_seg(t, shown, 1'b1);
    e.seg_nolz = exp_seg(t, shown, 1'b0);
    if (ld) begin
      staged = v;
      if (bnd) begin
        shown = v;
        pend  = 1'b0;
      end else begin
        pend = 1'b1;
      end
    end else if (bnd && pend) begin
      shown = staged;
      pend  = 1'b0;
    end
    e.pend = pend;
    sb.push_back(e);
    t++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, rnd_val());
  endtask

  task automatic load_at(input int phase, input val_t v);
    while ((t % FRAME) != phase) step(1'b0, rnd_val());
    step(1'b1, v);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    load  = 1'b0;
    sb.delete();
    #1;
    check("rst_an_lz", 32'(an_a), 32'hF);
    check("rst_seg_lz", 32'(seg_a), 32'h7F);
    check("rst_pend_lz", 32'(pend_a), 32'h0);
    check("rst_an_nolz", 32'(an_b), 32'hF);
    check("rst_seg_nolz", 32'(seg_b), 32'h7F);
    check("rst_pend_nolz", 32'(pend_b), 32'h0);
    t      = 0;
    shown  = '{d0: 4'h0, d1: 4'h0, s: 1'b1};
    staged = shown;
    pend   = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Monitor: compare every expected entry whose edge has already occurred
  always @(negedge clk) begin : monitor
    exp_t me;
    while (sb.size() > 0 && sb[0].cyc <= edge_cnt) begin
      me = sb.pop_front();
      check("an_lz", 32'(an_a), 32'(me.an));
      check("an_nolz", 32'(an_b), 32'(me.an));
      check("seg_lz", 32'(seg_a), 32'(me.seg_lz));
      check("seg_nolz", 32'(seg_b), 32'(me.seg_nolz));
      check("pending_lz", 32'(pend_a), 32'(me.pend));
      check("pending_nolz", 32'(pend_b), 32'(me.pend));
      check("one_anode_max", 32'($countones(~an_a) <= 1), 32'd1);
    end
  end

  initial begin
    do_reset();
    idle(3);
    load_at(5, '{d0: 4'h5, d1: 4'h0, s: 1'b0});
    idle(40);
    load_at(10, '{d0: 4'h0, d1: 4'h8, s: 1'b0});
    idle(40);
    load_at(5, '{d0: 4'h2, d1: 4'h1, s: 1'b1});
    load_at(20, '{d0: 4'hF, d1: 4'h3, s: 1'b1});
    idle(40);
    load_at(FRAME - 1, '{d0: 4'hA, d1: 4'h0, s: 1'b0});
    idle(FRAME);
    load_at(7, '{d0: 4'h6, d1: 4'hC, s: 1'b1});
    load_at(FRAME - 1, '{d0: 4'h9, d1: 4'hE, s: 1'b0});
    idle(FRAME + 4);
    load_at(9, '{d0: 4'h7, d1: 4'h7, s: 1'b0});
    idle(3);
    do_reset();
    idle(2 * FRAME);
    for (int i = 0; i < 1200; i++) begin
      step($urandom_range(0, 11) == 0, rnd_val());
    end
    @(posedge clk);
    @(negedge clk);
    #1;
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
